spi_tx_arbiter: RTL
===================

SPI_TX_ARBITER -- requirements
Module: spi_tx_arbiter

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, meaning the AXIS tdata width on all ports.
REQ-002 The module SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning the stall cycles allowed mid-packet before abort; the counter width is $clog2(TIMEOUT_CYCLES+1).
REQ-003 clk  input  1  sole clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 s0_axis_tdata/tvalid/tready/tlast  in/in/out/in  DATA_WIDTH/1/1/1  source 0, the Wishbone-master response stream.
REQ-006 s1_axis_tdata/tvalid/tready/tlast  in/in/out/in  DATA_WIDTH/1/1/1  source 1, the telemetry/status stream.
REQ-007 m_axis_tdata/tvalid/tready/tlast  out/out/in/out  DATA_WIDTH/1/1/1  merged stream to the SPI TX adapter.
REQ-008 spi_cs_n  input  1  SPI chip select, already synchronous to clk.
REQ-009 active_src  output  2  one-hot current grant; 00 when no grant is held.
REQ-010 drop_count  output  8  saturating count of beats discarded by aborts.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, PASS, DRAIN.
REQ-012 In IDLE, m_axis_tvalid, s0_axis_tready and s1_axis_tready SHALL all be 0.
REQ-013 In IDLE with any source tvalid=1, the FSM SHALL register the grant and enter PASS on the next edge, giving one cycle of arbitration latency.
REQ-014 Arbitration SHALL be round-robin at packet granularity: with both sources valid, the source not granted last wins; after reset, source 0 has priority.
REQ-015 In PASS, m_axis_tdata, tvalid and tlast SHALL combinationally follow the granted source, and the granted tready SHALL equal m_axis_tready.
REQ-016 In PASS, the non-granted tready SHALL be 0.
REQ-017 A grant SHALL be held until a beat with tlast=1 completes a handshake (tvalid&tready); the FSM then returns to IDLE, leaving one bubble cycle between packets.
REQ-018 The FSM SHALL register spi_cs_n into cs_q, whose reset value is 1; a CS deassert event is spi_cs_n=1 and cs_q=0.
REQ-019 A CS deassert event in PASS without a tlast handshake in the same cycle SHALL move the FSM to DRAIN.
REQ-020 A stall counter SHALL clear on entry to PASS and on every handshake in PASS, and increment on every other cycle in PASS.
REQ-021 When the stall counter reaches TIMEOUT_CYCLES without a handshake in that cycle, the FSM SHALL enter DRAIN.
REQ-022 In DRAIN, m_axis_tvalid SHALL be 0, the granted tready SHALL be 1 and the other tready 0.
REQ-023 Every beat accepted in DRAIN SHALL increment drop_count, saturating at 255.
REQ-024 DRAIN SHALL exit to IDLE after accepting a beat with tlast=1.
REQ-025 Simultaneous events SHALL resolve as follows: a tlast handshake beats both a CS deassert event and a timeout (go to IDLE, no drain); a CS deassert in IDLE or DRAIN has no effect.
REQ-026 The source that received the DRAIN grant SHALL count as last-served for round-robin.
REQ-027 active_src SHALL be 01 or 10 in PASS and DRAIN, and 00 in IDLE.

Reset
REQ-028 On rst_n=0, the following SHALL apply asynchronously: state=IDLE, last-served=source 1 (so source 0 has priority), stall counter=0, drop_count=0, cs_q=1, and all tready, m_axis_tvalid, m_axis_tlast, active_src and m_axis_tdata=0.
REQ-029 Reset asserted mid-packet SHALL abandon the packet without draining; after release, the FSM SHALL start in IDLE.

Verification
REQ-030 Both sources valid at once, s0 sends 3 bytes (A0,A1,A2, tlast on A2), s1 sends 2 bytes (B0,B1) -> m_axis carries A0 A1 A2, one idle cycle, then B0 B1, with active_src 01 then 00 then 10.
REQ-031 s0 sends 3 back-to-back packets while s1 is continuously valid -> output alternates s0,s1,s0,s1 packet by packet, and no packet interleaves beats from the other source.
REQ-032 s1 sends a 5-byte packet, spi_cs_n rises after beat 2 -> m_axis_tvalid drops, the remaining 3 beats are drained, drop_count=3, FSM returns to IDLE.
REQ-033 TIMEOUT_CYCLES=16, m_axis_tready held at 0 mid-packet -> DRAIN entered exactly 16 cycles after the last handshake, and the remainder of the packet is discarded.
REQ-034 spi_cs_n rises in the same cycle as a tlast handshake -> no DRAIN, drop_count is unchanged.
REQ-035 300 beats are discarded across several aborts -> drop_count=255; rst_n is then pulsed low mid-PASS -> all outputs read 0 immediately, and the FSM is in IDLE after release.

Source files
------------

// File: rtl/spi_tx_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | spi_tx_arbiter                                                              |
// | Two-source AXI-Stream packet arbiter feeding an SPI TX adapter, with        |
// | chip-select / stall-timeout abort and drain of the interrupted packet.      |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module spi_tx_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic                  s0_axis_tvalid,
  output logic                  s0_axis_tready,
  input  logic                  s0_axis_tlast,

  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic                  s1_axis_tvalid,
  output logic                  s1_axis_tready,
  input  logic                  s1_axis_tlast,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,

  input  logic                  spi_cs_n,
  output logic [1:0]            active_src,
  output logic [7:0]            drop_count
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // The counter reaches TIMEOUT_CYCLES on the edge that follows this value
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             grant;        // 0 = source 0, 1 = source 1
  logic             grant_next;
  logic             last_served;
  logic             last_served_next;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] stall_next;
  logic [7:0]       drop_next;
  logic             cs_q;

  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  src_ready;
  logic                  pick;
  logic                  handshake;
  logic                  cs_event;
  logic [1:0]            grant_onehot;

  assign sel_valid    = grant ? s1_axis_tvalid : s0_axis_tvalid;
  assign sel_last     = grant ? s1_axis_tlast  : s0_axis_tlast;
  assign sel_data     = grant ? s1_axis_tdata  : s0_axis_tdata;
  assign handshake    = sel_valid & m_axis_tready;
  assign cs_event     = spi_cs_n & ~cs_q;
  assign grant_onehot = grant ? 2'b10 : 2'b01;

  // Round robin: on contention the source not served last wins
  always_comb begin
    pick = 1'b0;
    if (s0_axis_tvalid && s1_axis_tvalid) begin
      pick = ~last_served;
    end else begin
      pick = s1_axis_tvalid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= 1'b0;
      last_served <= 1'b1;
      stall_cnt   <= '0;
      drop_count  <= 8'd0;
      cs_q        <= 1'b1;
    end else begin
      state       <= state_next;
      grant       <= grant_next;
      last_served <= last_served_next;
      stall_cnt   <= stall_next;
      drop_count  <= drop_next;
      cs_q        <= spi_cs_n;
    end
  end

  always_comb begin
    state_next       = state;
    grant_next       = grant;
    last_served_next = last_served;
    stall_next       = stall_cnt;
    drop_next        = drop_count;
    src_ready        = 1'b0;
    m_axis_tvalid    = 1'b0;
    m_axis_tlast     = 1'b0;
    m_axis_tdata     = '0;
    active_src       = 2'b00;

    case (state)
      IDLE: begin
        if (s0_axis_tvalid || s1_axis_tvalid) begin
          grant_next       = pick;
          last_served_next = pick;
          stall_next       = '0;
          state_next       = PASS;
        end
      end

      PASS: begin
        m_axis_tvalid = sel_valid;
        m_axis_tlast  = sel_last;
        m_axis_tdata  = sel_data;
        src_ready     = m_axis_tready;
        active_src    = grant_onehot;
        stall_next    = handshake ? '0 : stall_cnt + CNT_W'(1);
        // A completed packet wins over both abort causes
        if (handshake && sel_last) begin
          state_next = IDLE;
        end else if (cs_event) begin
          state_next = DRAIN;
        end else if (!handshake && stall_cnt == STALL_LAST) begin
          state_next = DRAIN;
        end
      end

      DRAIN: begin
        src_ready  = 1'b1;
        active_src = grant_onehot;
        if (sel_valid) begin
          if (drop_count != 8'hFF) begin
            drop_next = drop_count + 8'd1;
          end
          if (sel_last) begin
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign s0_axis_tready = src_ready & ~grant;
  assign s1_axis_tready = src_ready &  grant;

endmodule
`default_nettype wire
